// File: rtl/video_timing_pkg.sv
// Shared timing defaults, widths and lock-state encoding for the video sync decoder.
package video_timing_pkg;

    localparam int unsigned POS_W       = 10;
    localparam int unsigned COLOR_W     = 8;
    localparam int unsigned LINE_LEN_W  = 11;
    localparam int unsigned FRAME_LEN_W = 10;
    localparam int unsigned LOCK_CNT_W  = 8;

    localparam int unsigned DEF_H_ACTIVE   = 640;
    localparam int unsigned DEF_H_TOTAL    = 800;
    localparam int unsigned DEF_H_SYNC_END = 752;
    localparam int unsigned DEF_V_ACTIVE   = 480;
    localparam int unsigned DEF_V_TOTAL    = 525;
    localparam int unsigned DEF_V_SYNC_END = 492;
    localparam int unsigned DEF_LOCK_LINES = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        HLOCK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    typedef struct packed {
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } rgb_t;

endpackage

// File: rtl/video_sync_decoder_if.sv
// Sync/pixel input bundle and recovered-timing output bundle of the decoder.
interface video_sync_decoder_if;
    import video_timing_pkg::*;

    logic                   i_hsync;
    logic                   i_vsync;
    logic [COLOR_W-1:0]     i_r;
    logic [COLOR_W-1:0]     i_g;
    logic [COLOR_W-1:0]     i_b;
    logic [POS_W-1:0]       o_hpos;
    logic [POS_W-1:0]       o_vpos;
    logic                   o_visible;
    logic [COLOR_W-1:0]     o_r;
    logic [COLOR_W-1:0]     o_g;
    logic [COLOR_W-1:0]     o_b;
    logic                   o_locked;
    logic                   o_frame_start;
    logic                   o_err;
    logic [LINE_LEN_W-1:0]  o_line_len;

    modport slave (
        input  i_hsync, i_vsync, i_r, i_g, i_b,
        output o_hpos, o_vpos, o_visible, o_r, o_g, o_b,
        output o_locked, o_frame_start, o_err, o_line_len
    );

    modport master (
        output i_hsync, i_vsync, i_r, i_g, i_b,
        input  o_hpos, o_vpos, o_visible, o_r, o_g, o_b,
        input  o_locked, o_frame_start, o_err, o_line_len
    );

endinterface

// File: rtl/period_meter.sv
// Saturating mark-to-mark counter; the first mark after reset or clr only arms it.
module period_meter #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         mark,
    input  logic         clr,
    output logic [W-1:0] period_c,
    output logic         meas_c,
    output logic         sat_c
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         armed_q, armed_d;

    // An enable coinciding with the mark belongs to the new period.
    always_comb begin
        cnt_d   = cnt_q;
        armed_d = armed_q;
        if (mark) begin
            cnt_d   = W'(en);
            armed_d = 1'b1;
        end else if (en && (cnt_q != MAX)) begin
            cnt_d = cnt_q + W'(1);
        end
        if (clr) armed_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
        end
    end

    assign period_c = cnt_q;
    assign meas_c   = mark & armed_q;
    assign sat_c    = armed_q & (cnt_q == MAX);

endmodule

// File: rtl/video_sync_decoder.sv
// Recovers pixel position from raw h/v syncs and tracks timing lock.
module video_sync_decoder
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE        = DEF_H_ACTIVE,
    parameter int unsigned H_TOTAL         = DEF_H_TOTAL,
    parameter int unsigned H_SYNC_END      = DEF_H_SYNC_END,
    parameter int unsigned V_ACTIVE        = DEF_V_ACTIVE,
    parameter int unsigned V_TOTAL         = DEF_V_TOTAL,
    parameter int unsigned V_SYNC_END      = DEF_V_SYNC_END,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned LOCK_LINES      = DEF_LOCK_LINES
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    video_sync_decoder_if.slave   bus
);

    logic                   hs_a, vs_a, h_tr, v_tr, h_wrap;
    logic                   hs_prev_q, vs_prev_q;
    logic [POS_W-1:0]       h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    lock_state_e            state_q, state_d;
    logic [LOCK_CNT_W-1:0]  good_lines_q, good_lines_d;
    logic                   clean_q, clean_d;
    logic                   meter_clr;
    logic [LINE_LEN_W-1:0]  line_period, line_len_q, line_len_d;
    logic [FRAME_LEN_W-1:0] frame_period;
    logic                   line_meas, line_sat, frame_meas, frame_sat;
    logic                   line_good, line_bad, frame_bad;
    logic                   vis_q, vis_d, fs_q, fs_d, err_q, err_d, locked_q, locked_d;
    rgb_t                   pix_q, pix_d;

    assign hs_a = SYNC_ACTIVE_LOW ? ~bus.i_hsync : bus.i_hsync;
    assign vs_a = SYNC_ACTIVE_LOW ? ~bus.i_vsync : bus.i_vsync;
    assign h_tr = hs_prev_q & ~hs_a;
    assign v_tr = vs_prev_q & ~vs_a;

    // Position of the sample being taken this clock; registered it becomes o_hpos/o_vpos.
    always_comb begin
        h_wrap  = 1'b0;
        h_cnt_d = h_cnt_q + POS_W'(1);
        v_cnt_d = v_cnt_q;
        if (h_tr) begin
            h_cnt_d = POS_W'(H_SYNC_END);
        end else if (h_cnt_q == POS_W'(H_TOTAL - 1)) begin
            h_cnt_d = '0;
            h_wrap  = 1'b1;
        end
        if (v_tr) begin
            v_cnt_d = POS_W'(V_SYNC_END);
        end else if (h_wrap) begin
            v_cnt_d = (v_cnt_q == POS_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + POS_W'(1);
        end
    end

    period_meter #(.W(LINE_LEN_W)) u_line_meter (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .en       (1'b1),
        .mark     (h_tr),
        .clr      (meter_clr),
        .period_c (line_period),
        .meas_c   (line_meas),
        .sat_c    (line_sat)
    );

    period_meter #(.W(FRAME_LEN_W)) u_frame_meter (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .en       (h_tr),
        .mark     (v_tr),
        .clr      (meter_clr),
        .period_c (frame_period),
        .meas_c   (frame_meas),
        .sat_c    (frame_sat)
    );

    assign line_good = line_meas && (line_period == LINE_LEN_W'(H_TOTAL));
    assign line_bad  = (line_meas && !line_good) || line_sat;
    assign frame_bad = (frame_meas && (frame_period != FRAME_LEN_W'(V_TOTAL))) || frame_sat;

    // A frame only counts toward lock if every line in it was measured and good.
    always_comb begin
        state_d      = state_q;
        good_lines_d = good_lines_q;
        clean_d      = clean_q;
        err_d        = 1'b0;
        if (v_tr) clean_d = (state_q != SEARCH) || (good_lines_q != '0);
        if (line_bad) clean_d = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (line_bad) begin
                    good_lines_d = '0;
                end else if (line_good) begin
                    good_lines_d = good_lines_q + LOCK_CNT_W'(1);
                    if (good_lines_d >= LOCK_CNT_W'(LOCK_LINES)) state_d = HLOCK;
                end
            end
            HLOCK: begin
                if (line_bad) begin
                    state_d = SEARCH;
                end else if (frame_meas && clean_q &&
                             (frame_period == FRAME_LEN_W'(V_TOTAL))) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (line_bad || frame_bad) begin
                    state_d = SEARCH;
                    err_d   = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
        meter_clr = (state_d == SEARCH) && (state_q != SEARCH);
        if (meter_clr) begin
            good_lines_d = '0;
            clean_d      = 1'b0;
        end
    end

    always_comb begin
        locked_d   = (state_d == LOCKED);
        vis_d      = locked_d && (h_cnt_d < POS_W'(H_ACTIVE)) && (v_cnt_d < POS_W'(V_ACTIVE));
        fs_d       = locked_d && (h_cnt_d == '0) && (v_cnt_d == '0);
        line_len_d = h_tr ? line_period : line_len_q;
        pix_d      = '{r: bus.i_r, g: bus.i_g, b: bus.i_b};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            state_q      <= SEARCH;
            good_lines_q <= '0;
            clean_q      <= 1'b0;
            line_len_q   <= '0;
            vis_q        <= 1'b0;
            fs_q         <= 1'b0;
            err_q        <= 1'b0;
            locked_q     <= 1'b0;
            pix_q        <= '0;
        end else begin
            hs_prev_q    <= hs_a;
            vs_prev_q    <= vs_a;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            state_q      <= state_d;
            good_lines_q <= good_lines_d;
            clean_q      <= clean_d;
            line_len_q   <= line_len_d;
            vis_q        <= vis_d;
            fs_q         <= fs_d;
            err_q        <= err_d;
            locked_q     <= locked_d;
            pix_q        <= pix_d;
        end
    end

    assign bus.o_hpos        = h_cnt_q;
    assign bus.o_vpos        = v_cnt_q;
    assign bus.o_visible     = vis_q;
    assign bus.o_r           = pix_q.r;
    assign bus.o_g           = pix_q.g;
    assign bus.o_b           = pix_q.b;
    assign bus.o_locked      = locked_q;
    assign bus.o_frame_start = fs_q;
    assign bus.o_err         = err_q;
    assign bus.o_line_len    = line_len_q;

endmodule

// File: doc/video_sync_decoder.md
VIDEO_SYNC_DECODER -- requirements
Module: video_sync_decoder

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_TOTAL, default 800: clocks per line.
REQ-003 Parameter H_SYNC_END, default 752: hpos of the first clock after hsync deasserts.
REQ-004 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-005 Parameter V_TOTAL, default 525: lines per frame.
REQ-006 Parameter V_SYNC_END, default 492: vpos of the first line after vsync deasserts.
REQ-007 Parameter SYNC_ACTIVE_LOW, default 1: sync input polarity (1 = asserted low).
REQ-008 Parameter LOCK_LINES, default 2: consecutive correct line periods needed for horizontal lock.
REQ-009 i_clk  in  1  pixel clock; one clock, all logic on its rising edge.
REQ-010 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-011 i_hsync  in  1  horizontal sync from the video source.
REQ-012 i_vsync  in  1  vertical sync from the video source.
REQ-013 i_r, i_g, i_b  in  8 each  pixel colour, same cycle as the syncs.
REQ-014 o_hpos  out  10  recovered horizontal position.
REQ-015 o_vpos  out  10  recovered vertical position.
REQ-016 o_visible  out  1  recovered pixel is in the active area and the decoder is locked.
REQ-017 o_r, o_g, o_b  out  8 each  colour aligned with o_hpos/o_vpos.
REQ-018 o_locked  out  1  state is LOCKED.
REQ-019 o_frame_start  out  1  one-clock pulse when o_hpos=0 and o_vpos=0 while locked.
REQ-020 o_err  out  1  one-clock pulse on loss of lock.
REQ-021 o_line_len  out  11  last measured line period in clocks.

Function
REQ-022 The decoder normalises sync polarity internally. "Asserted" means active per SYNC_ACTIVE_LOW.
- Previous-sample registers drive edge detection.
- A trailing edge means prev asserted and current deasserted.
REQ-023 h counter:
- On an hsync trailing edge, load H_SYNC_END.
- Otherwise wrap to 0 after H_TOTAL-1, else increment.
- A trailing edge resynchronises the counter in every state.
REQ-024 v counter:
- On a vsync trailing edge, load V_SYNC_END.
- Otherwise advance (wrapping after V_TOTAL-1) whenever the h counter wraps from H_TOTAL-1 to 0.
- If h and v trailing edges coincide, both loads apply.
REQ-025 Latency: o_hpos, o_vpos, o_r, o_g, o_b and o_visible are registered, 1 clock after the input sample they describe.
REQ-026 o_visible is 1 only when LOCKED, hpos<H_ACTIVE and vpos<V_ACTIVE.
- Otherwise o_visible=0.
- o_r, o_g, o_b pass through regardless of o_visible.
REQ-027 Line meter:
- Counts clocks between consecutive hsync trailing edges.
- Saturates at 2047.
- Latches into o_line_len on each trailing edge.
REQ-028 Frame meter:
- Counts hsync trailing edges between consecutive vsync trailing edges.
- Saturates at 1023.
REQ-029 States are SEARCH, HLOCK and LOCKED.
- SEARCH -> HLOCK: LOCK_LINES consecutive measured lines equal H_TOTAL.
- HLOCK -> LOCKED: a full measured frame equals V_TOTAL lines and every line in it equals H_TOTAL.
- HLOCK -> SEARCH: any bad line, with no o_err pulse.
- Any bad line or frame, or a saturated meter, forces LOCKED -> SEARCH and o_err=1 for one clock.
REQ-030 A partial line or frame measured after reset, or after re-entering SEARCH, is discarded.

Reset
REQ-031 On i_rst_n low, all outputs are 0 immediately (asynchronously).
- State = SEARCH.
- Counters, meters and edge registers are cleared; prev sync is treated as deasserted.
REQ-032 Reset asserted mid-frame discards all lock progress; a fresh LOCK_LINES lines plus one full frame are needed after release.

Structure
REQ-033 Package video_timing_pkg holds:
- default timing constants (640x480 values above);
- the state enum {SEARCH, HLOCK, LOCKED};
- shared width constants.
REQ-034 One sub-module, period_meter: a saturating edge-to-edge counter, parameterised by width.
- Instance 1 counts clocks per line.
- Instance 2 counts lines per frame (its count enable is the hsync trailing edge).

Verification
REQ-035 Nominal 640x480 sync (SYNC_ACTIVE_LOW) driven from reset:
- o_locked rises within 2 lines plus 1 frame;
- o_hpos/o_vpos then equal the source position delayed 1 clock;
- o_frame_start pulses once per 420000 clocks.
REQ-036 Locked, one line lengthened to 801 clocks -> o_line_len=801, o_err pulses once, o_locked=0, o_visible=0; relock after 2 good lines plus 1 frame.
REQ-037 Locked, hsync held deasserted for 2100 clocks -> o_line_len=2047 at the next edge, o_err pulse, state SEARCH.
REQ-038 Frame of 524 lines while in HLOCK -> no transition to LOCKED and no o_err; the next 525-line frame locks.
REQ-039 i_rst_n pulsed low at hpos 300 / vpos 200 -> all outputs 0 during reset; o_locked stays 0 until a full relock sequence completes.
REQ-040 Pixel at source position (639,479) with colour 0xFF/0x00/0x80 -> output one clock later with o_visible=1; the pixel at (640,479) -> o_visible=0.
